cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the 128-bit-block main memory.
- Stores NUM_BLOCKS blocks of 4 x 32-bit words with valid, dirty and tag bits.
- Hits are served locally. Misses write back a dirty victim block, then fetch the missing block from main memory over the memory's block interface (readWrite, 10-bit byte addr, 128-bit data).

Parameters:
INDEX_BITS, 2, index width; NUM_BLOCKS = 2**INDEX_BITS; tag width = 6 - INDEX_BITS
MEM_LATENCY, 4, cycles spent in each memory transfer state (>= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  CPU access request, sampled only when ready=1
readWrite  input  1  0 = load, 1 = store
addr  input  10  CPU byte address; [1:0] ignored, [3:2] word, [3+INDEX_BITS:4] index, [9:4+INDEX_BITS] tag
writeData  input  32  store data
readData  output  32  load result, registered, held until next done
ready  output  1  high in IDLE (request accepted)
done  output  1  one-cycle pulse, access complete
memReadWrite  output  1  to main memory: 0 read, 1 write
memAddr  output  10  block byte address to main memory, [3:0] always 0
memWriteData  output  128  victim block, {w3,w2,w1,w0}
memReadData  input  128  block from main memory (combinational read)

Behaviour:
- Reset (async): state IDLE, all valid/dirty = 0, done = 0, readData = 0, memReadWrite = 0, memAddr = 0, memWriteData = 0. Data and tag arrays are not cleared.
- All outputs are registered. ready = (state == IDLE).
- IDLE: on an edge with req = 1, latch addr/readWrite/writeData and go to COMPARE. With req = 0, stay.
- COMPARE: hit = valid[idx] & tag[idx] == latched tag.
  - Hit load: readData <= word, done <= 1, go to IDLE.
  - Hit store: replace the word, dirty <= 1, done <= 1, go to IDLE.
  - Miss with valid & dirty: go to WRITEBACK. Load memAddr <= {old tag, idx, 4'b0}, memWriteData <= block, memReadWrite <= 1, counter <= 0.
  - Other misses: go to ALLOCATE. Load memAddr <= {new tag, idx, 4'b0}, memReadWrite <= 0, counter <= 0.
- WRITEBACK: hold memAddr, memWriteData and memReadWrite = 1 stable for MEM_LATENCY cycles. On the last cycle: memReadWrite <= 0, memAddr <= new block address, dirty <= 0, go to ALLOCATE. memAddr must never change while memReadWrite = 1, because main memory writes on level.
- ALLOCATE: after MEM_LATENCY cycles, capture memReadData into the block, tag <= new tag, valid <= 1, dirty <= 0, go to COMPARE. The retry in COMPARE always hits.
- done is high exactly one cycle, in the IDLE cycle after completion; a new req is accepted in that same cycle. req while not IDLE is ignored (not queued).
- Latency counts from the cycle req is sampled (cycle 0) to the cycle done is high:
  - hit: 2
  - clean miss: 3 + MEM_LATENCY
  - dirty miss: 3 + 2*MEM_LATENCY
- Store miss: allocate first, then the store hits in COMPARE and sets dirty. Memory is never written with partial-block data.
- Reset mid-miss: abort immediately; the line is left invalid. Memory writes already performed stand. memReadWrite drops with reset.

Test Plan (INDEX_BITS=2, MEM_LATENCY=4, memory word i initialised to i):
1. Reset, load 0x014 -> memReadWrite stays 0, memAddr=0x010, done in cycle 7, readData=5.
2. Then load 0x018 -> hit, done in cycle 2, readData=6, memAddr/memReadWrite unchanged.
3. Store 0x01C = 0xDEADBEEF -> hit, done cycle 2. Then load 0x01C -> 0xDEADBEEF. Memory word 7 still reads 7.
4. Load 0x11C (same index 1, tag 4) -> memReadWrite=1 for 4 cycles with memAddr=0x010 and memWriteData={0xDEADBEEF,6,5,4}. Then memAddr=0x110 read; done cycle 11, readData=0x47.
5. Pulse req mid-miss with another address -> ignored, no extra done. Hold req high through done -> next access accepted back-to-back, hit done 2 cycles later.
6. Assert reset during ALLOCATE -> ready=1, done=0, memReadWrite=0. Reload the same address -> misses again (clean-miss latency 7).

Source files
------------

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and block memory.
// Latency: hit 2 cycles, clean miss 3+MEM_LATENCY, dirty miss 3+2*MEM_LATENCY (req sample to done).
// Backpressure: ready is high only in IDLE; req while busy is dropped, not queued.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req/readWrite/addr/writeData  CPU request (load=0/store=1), sampled when ready=1
//   readData/ready/done   registered load result, idle indication, one-cycle completion pulse
//   memReadWrite/memAddr/memWriteData/memReadData  128-bit block port to main memory
module cache_ctrl #(
    parameter int INDEX_BITS  = 2,
    parameter int MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         readWrite,
    input  logic [9:0]   addr,
    input  logic [31:0]  writeData,
    output logic [31:0]  readData,
    output logic         ready,
    output logic         done,
    output logic         memReadWrite,
    output logic [9:0]   memAddr,
    output logic [127:0] memWriteData,
    input  logic [127:0] memReadData
);
    localparam int NUM_BLOCKS = 2 ** INDEX_BITS;
    localparam int TAG_W      = 6 - INDEX_BITS;
    localparam int CNT_W      = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t              state_q, state_d;
    logic [9:2]          waddr_q, waddr_d;     // latched word address
    logic                rw_q, rw_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [31:0]         read_data_q, read_data_d;
    logic                done_q, done_d;
    logic                mem_rw_q, mem_rw_d;
    logic [9:0]          mem_addr_q, mem_addr_d;
    logic [127:0]        mem_wdat_q, mem_wdat_d;

    // Data and tag storage carry no reset; valid bits guard them.
    logic [127:0]        blk_q [NUM_BLOCKS];
    logic [TAG_W-1:0]    tag_arr_q [NUM_BLOCKS];
    logic                blk_we, tag_we;
    logic [127:0]        blk_wdat;

    // Byte offset is irrelevant: all accesses are whole words.
    logic addr_unused;
    assign addr_unused = ^addr[1:0];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      cur_tag;
    logic [1:0]            word_sel;
    logic [127:0]          cur_blk;
    logic                  hit;

    assign idx      = waddr_q[3+INDEX_BITS:4];
    assign cur_tag  = waddr_q[9:4+INDEX_BITS];
    assign word_sel = waddr_q[3:2];
    assign cur_blk  = blk_q[idx];
    assign hit      = valid_q[idx] && (tag_arr_q[idx] == cur_tag);

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        rw_d        = rw_q;
        wdat_d      = wdat_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        read_data_d = read_data_q;
        done_d      = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdat_d  = mem_wdat_q;
        blk_we      = 1'b0;
        tag_we      = 1'b0;
        blk_wdat    = cur_blk;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    waddr_d = addr[9:2];
                    rw_d    = readWrite;
                    wdat_d  = writeData;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (rw_q) begin
                        blk_wdat[{word_sel, 5'b0} +: 32] = wdat_q;
                        blk_we       = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        read_data_d = cur_blk[{word_sel, 5'b0} +: 32];
                    end
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    // Victim address/data are frozen for the whole write burst.
                    mem_addr_d = {tag_arr_q[idx], idx, 4'b0};
                    mem_wdat_d = cur_blk;
                    mem_rw_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_WRITEBACK;
                end else begin
                    mem_addr_d = {cur_tag, idx, 4'b0};
                    mem_rw_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (cnt_q == CNT_LAST) begin
                    // Drop the write strobe and switch address on the same edge,
                    // so the address never moves while a write is asserted.
                    mem_rw_d     = 1'b0;
                    mem_addr_d   = {cur_tag, idx, 4'b0};
                    dirty_d[idx] = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_ALLOCATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ALLOCATE: begin
                if (cnt_q == CNT_LAST) begin
                    blk_wdat     = memReadData;
                    blk_we       = 1'b1;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            rw_q        <= 1'b0;
            wdat_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdat_q  <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            rw_q        <= rw_d;
            wdat_q      <= wdat_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdat_q  <= mem_wdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (blk_we) blk_q[idx] <= blk_wdat;
        if (tag_we) tag_arr_q[idx] <= cur_tag;
    end

    assign ready        = (state_q == S_IDLE);
    assign done         = done_q;
    assign readData     = read_data_q;
    assign memReadWrite = mem_rw_q;
    assign memAddr      = mem_addr_q;
    assign memWriteData = mem_wdat_q;
endmodule
